// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp: parametrised multi-port register file with busy scoreboard.
//
// Register 0 is hardwired to zero and is never busy. Each write port commits
// on the rising edge. When several write ports target the same register in
// one cycle, the highest-numbered port wins. Reads have one cycle of latency
// and hold their last value while the read enable is low. BYPASS selects
// whether a read sees data and busy state written or reserved on the same
// edge (post-update) or the state from before that edge (pre-update).
//
// Handshake: there is no valid/ready pair and no backpressure. Every
// enabled read, write and reserve is accepted on the edge where its enable
// is high.
// ---------------------------------------------------------------------------
module regfile_mp #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 32,
   parameter int NUM_RD     = 2,
   parameter int NUM_WR     = 1,
   parameter int BYPASS     = 1,
   localparam int IDX_W     = $clog2(NUM_REGS)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [NUM_RD-1:0]            rd_en,
   input  logic [NUM_RD*IDX_W-1:0]      rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
   output logic [NUM_RD-1:0]            rd_busy,
   input  logic [NUM_WR-1:0]            wr_en,
   input  logic [NUM_WR*IDX_W-1:0]      wr_addr,
   input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
   input  logic                         rsv_en,
   input  logic [IDX_W-1:0]             rsv_addr,
   output logic [NUM_REGS-1:0]          busy_vec
);

   // Architectural state
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [NUM_REGS-1:0]   busy_q;

   // Unpacked views of the flattened port buses
   logic [IDX_W-1:0]      wa [NUM_WR];
   logic [DATA_WIDTH-1:0] wd [NUM_WR];
   logic [IDX_W-1:0]      ra [NUM_RD];

   // Per-register resolved write (enable plus winning data)
   logic [NUM_REGS-1:0]   reg_we;
   logic [DATA_WIDTH-1:0] reg_wd [NUM_REGS];

   // Next-state scoreboard
   logic [NUM_REGS-1:0]   busy_d;

   // Per-read-port value to be registered on the next enabled edge
   logic [DATA_WIDTH-1:0] rd_val [NUM_RD];
   logic [NUM_RD-1:0]     rd_bsy;

   // Slice the flat write and read buses into per-port fields
   always_comb begin
      for (int j = 0; j < NUM_WR; j++) begin
         wa[j] = wr_addr[j*IDX_W +: IDX_W];
         wd[j] = wr_data[j*DATA_WIDTH +: DATA_WIDTH];
      end
      for (int i = 0; i < NUM_RD; i++) begin
         ra[i] = rd_addr[i*IDX_W +: IDX_W];
      end
   end

   // Resolve write ports per register; later (higher) ports override earlier ones
   always_comb begin
      reg_we = '0;
      for (int r = 0; r < NUM_REGS; r++) begin
         reg_wd[r] = '0;
      end
      for (int r = 1; r < NUM_REGS; r++) begin
         for (int j = 0; j < NUM_WR; j++) begin
            if (wr_en[j] && (wa[j] == IDX_W'(r))) begin
               reg_we[r] = 1'b1;
               reg_wd[r] = wd[j];
            end
         end
      end
   end

   // Scoreboard update: writes clear, a reservation sets and takes priority
   always_comb begin
      busy_d = busy_q & ~reg_we;
      if (rsv_en) begin
         busy_d[rsv_addr] = 1'b1;
      end
      busy_d[0] = 1'b0;
   end

   // Read-port source select: pre-edge state, or post-edge state when bypassing
   always_comb begin
      for (int i = 0; i < NUM_RD; i++) begin
         rd_val[i] = regs[ra[i]];
         rd_bsy[i] = busy_q[ra[i]];
         if (BYPASS != 0) begin
            if (reg_we[ra[i]]) begin
               rd_val[i] = reg_wd[ra[i]];
            end
            rd_bsy[i] = busy_d[ra[i]];
         end
      end
   end

   // Register array; entry 0 is never enabled so it stays at its reset value
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NUM_REGS; r++) begin
            regs[r] <= '0;
         end
      end else begin
         for (int r = 0; r < NUM_REGS; r++) begin
            if (reg_we[r]) begin
               regs[r] <= reg_wd[r];
            end
         end
      end
   end

   // Busy scoreboard register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // Registered read outputs; each port holds while its enable is low
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_data <= '0;
         rd_busy <= '0;
      end else begin
         for (int i = 0; i < NUM_RD; i++) begin
            if (rd_en[i]) begin
               rd_data[i*DATA_WIDTH +: DATA_WIDTH] <= rd_val[i];
               rd_busy[i]                          <= rd_bsy[i];
            end
         end
      end
   end

   assign busy_vec = busy_q;

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the superscalar/pipelined RV32I core.
- Successor to the single-write/dual-read register file.
- Generalised in data width, register count, read-port count and write-port count.
- Adds an optional write-to-read bypass and a per-register busy scoreboard so issue logic can detect pending writes (RAW hazards).
- Sits between decode/issue (reads, reservations) and writeback (writes).

Parameters:
- DATA_WIDTH, 32, bits per register.
- NUM_REGS, 32, number of registers including hardwired register 0; must be a power of two, at least 2.
- NUM_RD, 2, number of read ports, at least 1.
- NUM_WR, 1, number of write ports, at least 1.
- BYPASS, 1, 1 = a read returns same-cycle write data; 0 = a read returns the pre-write value.
- IDX_W (derived localparam), $clog2(NUM_REGS), register index width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- rd_en  in  NUM_RD  per-port read enable.
- rd_addr  in  NUM_RD*IDX_W  read indices; port i occupies bits [i*IDX_W +: IDX_W].
- rd_data  out  NUM_RD*DATA_WIDTH  registered read data; port i occupies [i*DATA_WIDTH +: DATA_WIDTH].
- rd_busy  out  NUM_RD  registered busy flag of the register read on port i.
- wr_en  in  NUM_WR  per-port write enable.
- wr_addr  in  NUM_WR*IDX_W  write indices.
- wr_data  in  NUM_WR*DATA_WIDTH  write data.
- rsv_en  in  1  reserve request: mark rsv_addr busy (instruction issued with destination rd).
- rsv_addr  in  IDX_W  register to reserve.
- busy_vec  out  NUM_REGS  current scoreboard; bit 0 is always 0.

Behaviour:
- Reset (asynchronous, active-high): all registers cleared to 0, all busy bits 0, rd_data 0, rd_busy 0, busy_vec 0. Reset asserted mid-operation discards any in-flight write/reserve; the first edge after deassertion operates normally.
- Register 0: always reads 0 and is never busy. Writes and reservations targeting index 0 are ignored.
- Write: on a rising edge with wr_en[j]=1 and wr_addr[j]!=0, the register takes wr_data[j].
- Multiple write ports, same address, same cycle: the highest-numbered port wins. Writes to different addresses all commit.
- Read latency: 1 cycle. On an edge with rd_en[i]=1, rd_data[i] and rd_busy[i] load from rd_addr[i]. With rd_en[i]=0 both hold their previous values.
- BYPASS=1: a read of address A in the same cycle as an enabled write to A returns the winning write data. rd_busy reflects the post-update busy state.
- BYPASS=0: a read returns the pre-edge register value and the pre-edge busy bit.
- Multiple read ports may read the same address; each returns identical data.
- Scoreboard, per edge:
  - An enabled write to A!=0 clears busy[A].
  - rsv_en=1 with rsv_addr!=0 sets busy[rsv_addr].
  - Reserve and write to the same address in the same cycle: reserve wins, busy stays 1 (a new producer supersedes the completing one).
  - Writing a non-busy register is legal and leaves it 0.
  - Reserving an already-busy register is legal and leaves it 1.
- busy_vec is the registered scoreboard with no bypass.
- No internal backpressure: every port is accepted every cycle.

Test Plan:
- Assert reset asynchronously mid-cycle after writing 0xDEADBEEF to x5 -> rd_data, rd_busy and busy_vec go to 0 immediately; a subsequent read of x5 returns 0.
- Write 0x12345678 to x0 and read x0 on both ports -> rd_data = 0 for both, busy_vec[0] = 0, including when rsv_addr=0.
- BYPASS=1: write 0xA5A5A5A5 to x7 while port 0 reads x7 (old value 0x11) -> next cycle rd_data[0] = 0xA5A5A5A5. BYPASS=0: same stimulus -> 0x11, then 0xA5A5A5A5 on a re-read.
- NUM_WR=2: port 0 writes 0x1 and port 1 writes 0x2 to x9 in the same cycle -> x9 reads 0x2. Port 0 to x3 and port 1 to x4 -> both commit.
- Reserve x12 -> busy_vec[12]=1; a read of x12 gives rd_busy=1. Write x12=0x55 -> busy clears, next read returns 0x55 with rd_busy=0.
- Same cycle: rsv_en on x12 plus wr_en to x12 -> data updated and busy_vec[12] stays 1. rd_en=0 for 3 cycles -> rd_data and rd_busy hold their values.
